// File: rtl/subword_mem_ctrl_pkg.sv
// Shared types for the sub-word load/store controller.
// Opcodes, access sizes, FSM states and the opcode decoder.
package subword_mem_ctrl_pkg;

  localparam int WORD_W = 64;

  localparam logic [10:0] OP_LDUR   = 11'h7C2;
  localparam logic [10:0] OP_LDURB  = 11'h1C2;
  localparam logic [10:0] OP_LDURH  = 11'h3C2;
  localparam logic [10:0] OP_LDURSW = 11'h5C4;
  localparam logic [10:0] OP_STUR   = 11'h7C0;
  localparam logic [10:0] OP_STURB  = 11'h1C0;
  localparam logic [10:0] OP_STURH  = 11'h3C0;
  localparam logic [10:0] OP_STURW  = 11'h5C0;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LRESP = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic  ld;
    logic  st;
    size_t size;
    logic  sext;
  } acc_t;

  function automatic acc_t decode(input logic [10:0] op);
    acc_t a;
    a = '0;
    a.size = SZ_D;
    unique case (1'b1)
      op == OP_LDUR:   a.ld = 1'b1;
      op == OP_LDURB:  begin a.ld = 1'b1; a.size = SZ_B; end
      op == OP_LDURH:  begin a.ld = 1'b1; a.size = SZ_H; end
      op == OP_LDURSW: begin
        a.ld = 1'b1;
        a.size = SZ_W;
        a.sext = 1'b1;
      end
      op == OP_STUR:   a.st = 1'b1;
      op == OP_STURB:  begin a.st = 1'b1; a.size = SZ_B; end
      op == OP_STURH:  begin a.st = 1'b1; a.size = SZ_H; end
      op == OP_STURW:  begin a.st = 1'b1; a.size = SZ_W; end
      default: ;
    endcase
    return a;
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [2:0] a);
    logic m;
    unique case (sz)
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      SZ_W:    m = |a[1:0];
      default: m = |a;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/subword_mem_ctrl_load_align.sv
// Load lane extraction: picks the addressed lane of the RAM word
// and zero- or sign-extends it to 64 bits.
module subword_mem_ctrl_load_align
  import subword_mem_ctrl_pkg::*;
(
  input  logic [63:0] rdata,
  input  size_t       size,
  input  logic        sext,
  input  logic [2:0]  lane,
  output logic [63:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  always_comb begin
    b = rdata[{lane, 3'b000} +: 8];
    h = rdata[{lane[2:1], 4'b0000} +: 16];
    w = rdata[{lane[2], 5'b00000} +: 32];
    data = rdata;
    unique case (size)
      SZ_B:    data = {56'b0, b};
      SZ_H:    data = {48'b0, h};
      SZ_W:    data = {{32{sext & w[31]}}, w};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/subword_mem_ctrl.sv
// Load/store controller with sub-word align and read-modify-write.
// Optional build macro: MISALIGN_TRAP_EN (fault misaligned accesses).
module subword_mem_ctrl
  import subword_mem_ctrl_pkg::*;
#(
  parameter int WORD   = WORD_W,
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [10:0]       opcode,
  input  logic [WORD-1:0]   address,
  input  logic [WORD-1:0]   write_data,
  output logic              resp_valid,
  output logic              resp_fault,
  output logic [WORD-1:0]   read_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  output logic [WORD-1:0]   ram_wdata,
  input  logic [WORD-1:0]   ram_rdata
);

  state_t            state;
  state_t            state_nx;
  acc_t              dec;
  acc_t              op_q;
  logic [RAM_AW+2:0] addr_q;
  logic [WORD-1:0]   wdata_q;
  logic [WORD-1:0]   merged;
  logic [WORD-1:0]   aligned;
  logic              hs;
  logic              bad;
  logic              unused_addr;

  assign unused_addr = ^address[WORD-1:RAM_AW+3];

  assign dec = decode(opcode);
  assign hs  = req_valid & req_ready;

`ifdef MISALIGN_TRAP_EN
  logic fault_q;

  assign bad = (dec.ld | dec.st)
             & misaligned(dec.size, address[2:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      fault_q <= 1'b0;
    else if (hs)
      fault_q <= bad;
  end

  assign resp_fault = (state == S_RESP) & fault_q;
`else
  assign bad        = 1'b0;
  assign resp_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        op_q    <= dec;
        addr_q  <= address[RAM_AW+2:0];
        wdata_q <= write_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (hs) begin
          unique case (1'b1)
            bad:    state_nx = S_RESP;
            dec.ld: state_nx = S_RD;
            dec.st: state_nx = (dec.size == SZ_D) ? S_WR : S_RD;
            default: state_nx = S_RESP;
          endcase
        end
      end
      S_RD:    state_nx = op_q.ld ? S_LRESP : S_WR;
      S_WR:    state_nx = S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end

  // Replace only the addressed lane of the word read in the RD cycle.
  always_comb begin
    merged = ram_rdata;
    unique case (op_q.size)
      SZ_B: merged[{addr_q[2:0], 3'b000} +: 8]    = wdata_q[7:0];
      SZ_H: merged[{addr_q[2:1], 4'b0000} +: 16]  = wdata_q[15:0];
      SZ_W: merged[{addr_q[2], 5'b00000} +: 32]   = wdata_q[31:0];
      default: merged = wdata_q;
    endcase
  end

  subword_mem_ctrl_load_align u_align (
    .rdata (ram_rdata),
    .size  (op_q.size),
    .sext  (op_q.sext),
    .lane  (addr_q[2:0]),
    .data  (aligned)
  );

  always_comb begin
    req_ready  = (state == S_IDLE);
    ram_re     = (state == S_RD);
    ram_we     = (state == S_WR);
    ram_addr   = addr_q[RAM_AW+2:3];
    ram_wdata  = (state == S_WR) ? merged : '0;
    resp_valid = (state == S_LRESP) | (state == S_RESP);
    read_data  = (state == S_LRESP) ? aligned : '0;
  end

endmodule
